// File: rtl/mem_arb_pkg.sv
// Shared types for mem_arbiter: FSM states, default widths and the captured-command record.
// The command record is sized by the package widths; retune them together with the top parameters.
package mem_arb_pkg;

    localparam int ADDR_W_DFLT = 16;
    localparam int DATA_W_DFLT = 16;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        RDWAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic                   wr;
        logic [ADDR_W_DFLT-1:0] addr;
        logic [DATA_W_DFLT-1:0] wdata;
        logic                   owner;
    } cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select; last-grant pointer favours requester 0 out of reset.
// Latency: grant is combinational from req; pointer updates on the edge after take.
// Backpressure: never grants an idle requester; take says the grant was actually used.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] grant
);

    logic last_q;
    logic last_d;

    always_comb begin
        grant  = 2'b00;
        last_d = last_q;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        if (take) begin
            last_d = grant[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter with round-robin grant; MEM_ARB_STATS_EN adds grant counters.
// Latency: write strobe N+1 after accept; read strobe N+1, response pulse N+3.
// Backpressure: req_ready only in IDLE, one command in flight at a time.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int DATA_W = DATA_W_DFLT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_wr,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            req_ready,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  mem_wr,
    output logic                  mem_rd,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wr_data,
    input  logic [DATA_W-1:0]     mem_rd_data
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]           grant_cnt0,
    output logic [15:0]           grant_cnt1
`endif
);

    state_t              state_q, state_d;
    cmd_t                cmd_q, cmd_d;
    logic                mem_wr_q, mem_wr_d;
    logic                mem_rd_q, mem_rd_d;
    logic [1:0]          rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]          grant;
    logic                win;
    logic                win_wr;

    rr_arb2 u_rr (
        .clk   (clk),
        .rst   (rst),
        .req   (req_valid),
        .take  (|req_ready),
        .grant (grant)
    );

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        mem_wr_d    = 1'b0;
        mem_rd_d    = 1'b0;
        rsp_valid_d = 2'b00;
        rsp_rdata_d = rsp_rdata_q;
        req_ready   = 2'b00;
        win         = grant[1];
        win_wr      = win ? req_wr[1] : req_wr[0];
        unique case (state_q)
            IDLE: begin
                if (!rst && (grant != 2'b00)) begin
                    req_ready   = grant;
                    cmd_d.wr    = win_wr;
                    cmd_d.owner = win;
                    cmd_d.addr  = win ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
                    // Reads leave the write-data bus untouched.
                    if (win_wr) begin
                        cmd_d.wdata = win ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
                    end
                    mem_wr_d = win_wr;
                    mem_rd_d = !win_wr;
                    state_d  = win_wr ? WRITE : READ;
                end
            end
            WRITE:   state_d = IDLE;
            READ:    state_d = RDWAIT;
            RDWAIT: begin
                if (!cmd_q.wr) begin
                    rsp_rdata_d = mem_rd_data;
                end
                rsp_valid_d = cmd_q.owner ? 2'b10 : 2'b01;
                state_d     = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            mem_wr_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            mem_wr_q    <= mem_wr_d;
            mem_rd_q    <= mem_rd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // The captured command doubles as the memory address/data register.
    assign mem_addr    = cmd_q.addr;
    assign mem_wr_data = cmd_q.wdata;
    assign mem_wr      = mem_wr_q;
    assign mem_rd      = mem_rd_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (req_valid[0] && req_ready[0] && (cnt0_q != 16'hFFFF)) begin
            cnt0_d = cnt0_q + 16'd1;
        end
        if (req_valid[1] && req_ready[1] && (cnt1_q != 16'hFFFF)) begin
            cnt1_d = cnt1_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= 16'd0;
            cnt1_q <= 16'd0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, memory data width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  2  per-requester command valid.
REQ-006 SHALL have port req_wr  input  2  per-requester op: 1 = write, 0 = read.
REQ-007 SHALL have port req_addr  input  2*ADDR_W  per-requester address; requester i at bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port req_wdata  input  2*DATA_W  per-requester write data, packed the same way.
REQ-009 SHALL have port req_ready  output  2  one-hot command accept.
REQ-010 SHALL have port rsp_valid  output  2  one-hot read-data valid, one-cycle pulse.
REQ-011 SHALL have port rsp_rdata  output  DATA_W  read data, shared by both requesters.
REQ-012 SHALL have ports mem_wr, mem_rd  output  1 each  memory strobes.
REQ-013 SHALL have ports mem_addr (ADDR_W) and mem_wr_data (DATA_W), both outputs, driving the memory address and write data.
REQ-014 SHALL have port mem_rd_data  input  DATA_W  memory read data, valid the cycle after mem_rd.

Function
REQ-015 SHALL treat a command as accepted in a cycle where req_valid[i] && req_ready[i].
REQ-016 SHALL implement FSM states IDLE, WRITE, READ, RDWAIT, RESP.
REQ-017 SHALL, in IDLE with any req_valid set, pick a winner, assert req_ready[winner] combinationally in the same cycle, capture that requester's op, addr and wdata, and go to WRITE or READ.
REQ-018 SHALL deassert req_ready in every state other than IDLE, and in IDLE when no req_valid is set.
REQ-019 SHALL arbitrate round-robin: when both requesters are valid, grant the one not granted last; a lone valid requester always wins.
REQ-020 SHALL make mem_wr, mem_rd, mem_addr and mem_wr_data registered outputs.
REQ-021 SHALL, in WRITE, drive mem_wr=1 with the captured addr and data for exactly one cycle, then return to IDLE.
REQ-022 SHALL, in READ, drive mem_rd=1 with the captured addr for exactly one cycle, then go to RDWAIT.
REQ-023 SHALL, in RDWAIT, register mem_rd_data into rsp_rdata, then go to RESP.
REQ-024 SHALL, in RESP, pulse rsp_valid[owner] for one cycle, then return to IDLE.
REQ-025 SHALL meet this latency: write accepted in cycle N gives mem_wr in N+1 and next accept no earlier than N+2; read accepted in N gives mem_rd in N+1, rsp_valid in N+3 and next accept no earlier than N+4.
REQ-026 SHALL never assert mem_wr and mem_rd in the same cycle.
REQ-027 SHALL hold rsp_rdata stable until the next read response.
REQ-028 SHALL hold mem_addr and mem_wr_data at their last values while the strobes are low.
REQ-029 SHALL never grant a requester whose req_valid is low.
REQ-030 SHALL ignore req_wr, req_addr and req_wdata of requesters that are not accepted.

Reset
REQ-031 SHALL, on rst, immediately set the state to IDLE and drive req_ready=0, rsp_valid=0, mem_wr=0, mem_rd=0, mem_addr=0, mem_wr_data=0, rsp_rdata=0.
REQ-032 SHALL, on rst, set the round-robin pointer so requester 0 wins the first tie.
REQ-033 SHALL, if rst asserts mid-operation, abandon the operation with no rsp_valid and no further memory strobe.

Configuration
REQ-034 SHALL, with MEM_ARB_STATS_EN defined, add output ports grant_cnt0 and grant_cnt1, each 16 bits.
REQ-035 SHALL increment grant_cntN on each accept by requester N, saturating at 16'hFFFF and clearing on rst.
REQ-036 SHALL, without MEM_ARB_STATS_EN, omit these ports and counters entirely.

Structure
REQ-037 SHALL place the FSM state enum, the ADDR_W/DATA_W defaults and a captured-command struct (wr, addr, wdata, owner) in package mem_arb_pkg.
REQ-038 SHALL put the round-robin winner selection and last-grant pointer in sub-module rr_arb2.

Verification
REQ-039 SHALL cover a single write: req0 writes addr 0x0003, data 0x00AB -> req_ready[0] in the same cycle, mem_wr=1 with addr 0x0003 and data 0x00AB one cycle later.
REQ-040 SHALL cover a single read: req1 reads 0x0003 with memory returning 0x00AB -> mem_rd in N+1, rsp_valid=2'b10 and rsp_rdata=0x00AB in N+3.
REQ-041 SHALL cover a tie: both requesters valid continuously after reset -> grants alternate 0,1,0,1.
REQ-042 SHALL cover a lone requester: req0 issues 4 back-to-back writes -> accepts every 2 cycles, req_ready[1] never high.
REQ-043 SHALL cover reset mid-read: rst asserted during RDWAIT -> no rsp_valid, all outputs 0, first tie after reset goes to req0.
REQ-044 SHALL cover stats, with MEM_ARB_STATS_EN: 3 grants to req0 and 2 to req1 -> grant_cnt0=3, grant_cnt1=2.
